// File: rtl/bs_pkg.sv
// Shared definitions for the barrel-shift pipeline: opcode encodings and the
// opcode decoder that turns a 3-bit opcode into the datapath controls.
package bs_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // Datapath controls derived from an opcode.
  //   shift : kill bits rotated past the edge (0 = pure rotate)
  //   left  : rotate/shift direction
  //   arith : fill killed bits with the operand MSB
  //   err   : opcode is not one of the five legal encodings
  typedef struct packed {
    logic shift;
    logic left;
    logic arith;
    logic err;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [2:0] op);
    ctrl_t c;
    // Illegal opcodes behave as a zero-length rotate so the operand passes through.
    c = '{shift: 1'b0, left: 1'b1, arith: 1'b0, err: 1'b1};
    case (op)
      OP_ROL:  c = '{shift: 1'b0, left: 1'b1, arith: 1'b0, err: 1'b0};
      OP_ROR:  c = '{shift: 1'b0, left: 1'b0, arith: 1'b0, err: 1'b0};
      OP_SLL:  c = '{shift: 1'b1, left: 1'b1, arith: 1'b0, err: 1'b0};
      OP_SRL:  c = '{shift: 1'b1, left: 1'b0, arith: 1'b0, err: 1'b0};
      OP_SRA:  c = '{shift: 1'b1, left: 1'b0, arith: 1'b1, err: 1'b0};
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bs_mask_gen.sv
// Thermometer mask generator. Marks the bit positions that a shift pushed
// past the operand edge; those positions are killed or sign-filled downstream.
module bs_mask_gen #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [SHW-1:0]   shamt,
  input  logic             shift,
  input  logic             left,
  output logic [WIDTH-1:0] mask
);

  // Left shift marks the low shamt bits; right shift marks the high shamt bits.
  always_comb begin
    mask = '0;
    if (shift) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (left) mask[k] = (k < int'(shamt));
        else      mask[k] = (k >= WIDTH - int'(shamt));
      end
    end
  end

endmodule

// File: rtl/bs_shift_pipe.sv
// Two-stage streaming barrel-shift unit. S1 decodes the opcode and rotates the
// operand; S2 applies the kill/sign-fill mask and holds the registered result.
// Both stages advance under a valid/ready handshake with full backpressure.
module bs_shift_pipe
  import bs_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_X,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_err
);

  logic             adv1;
  logic             adv2;
  ctrl_t            in_ctrl;
  logic [SHW-1:0]   rot_amt;
  logic [WIDTH-1:0] rot_x;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_r;
  logic [SHW-1:0]   s1_shamt;
  logic             s1_shift;
  logic             s1_left;
  logic             s1_arith;
  logic             s1_msb;
  logic             s1_err;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] y_next;

  // Stage advance: S2 may load when empty or being drained, S1 when empty or S2 moves.
  always_comb begin
    adv2    = ~o_valid | i_ready;
    adv1    = ~s1_valid | adv2;
    o_ready = adv1;
  end

  // Decode and rotate amount; a right rotate is a left rotate by -shamt mod WIDTH.
  always_comb begin
    in_ctrl = decode_op(i_op);
    if (in_ctrl.err)       rot_amt = '0;
    else if (in_ctrl.left) rot_amt = i_shamt;
    else                   rot_amt = -i_shamt;
  end

  // Logarithmic rotator: stage i rotates left by 2**i when rot_amt[i] is set.
  always_comb begin
    // NOTE: blocking assignments here on purpose -- each mux stage must see the
    // previous stage's value within the same evaluation; flops use <= instead.
    rot_x = i_X;
    for (int i = 0; i < SHW; i++) begin
      if (rot_amt[i]) rot_x = (rot_x << (1 << i)) | (rot_x >> (WIDTH - (1 << i)));
    end
  end

  // S1 occupancy: loads the input handshake whenever the stage advances.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)   s1_valid <= 1'b0;
    else if (adv1) s1_valid <= i_valid;
  end

  // S1 payload: captured only on an accepted operand, frozen otherwise.
  always_ff @(posedge i_clk) begin
    // NOTE: payload flops carry no reset; s1_valid gates every use of them.
    if (adv1 && i_valid) begin
      s1_r     <= rot_x;
      s1_shamt <= i_shamt;
      s1_shift <= in_ctrl.shift;
      s1_left  <= in_ctrl.left;
      s1_arith <= in_ctrl.arith;
      s1_msb   <= i_X[WIDTH-1];
      s1_err   <= in_ctrl.err;
    end
  end

  bs_mask_gen #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mask_gen (
    .shamt (s1_shamt),
    .shift (s1_shift),
    .left  (s1_left),
    .mask  (mask)
  );

  // Masked bits become zero, or the original MSB for arithmetic right shifts.
  always_comb begin
    y_next = (s1_r & ~mask) | (mask & {WIDTH{s1_arith & s1_msb}});
  end

  // S2 result register: holds steady while the downstream stalls.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_Y     <= '0;
      o_err   <= 1'b0;
    end else if (adv2) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_Y   <= y_next;
        o_err <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_bs_shift_pipe.sv
// Directed and random bench for bs_shift_pipe at WIDTH = 4. Every result is
// compared against an independent reference model through one check task.
module tb_bs_shift_pipe;

  localparam int WIDTH = 4;
  localparam int SHW   = 2;

  logic             clk = 1'b0;
  logic             i_rstn;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_X;
  logic [SHW-1:0]   i_shamt;
  logic [2:0]       i_op;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_Y;
  logic             o_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             err;
  } exp_t;

  exp_t             exp_q[$];
  int               n_out      = 0;
  bit               sb_on      = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] held_y;
  logic             held_err;

  bs_shift_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .i_clk   (clk),
    .i_rstn  (i_rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_X     (i_X),
    .i_shamt (i_shamt),
    .i_op    (i_op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_Y     (o_Y),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour written from the operation definitions, not the RTL structure.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [3:0] x,
                                     input logic [1:0] s);
    exp_t             e;
    int               n;
    logic [7:0]       dbl;
    logic signed [3:0] sx;
    n     = int'(s);
    e.err = 1'b0;
    case (op)
      3'b000: begin dbl = {x, x} >> (4 - n); e.y = dbl[3:0]; end
      3'b001: begin dbl = {x, x} >> n;       e.y = dbl[3:0]; end
      3'b010: e.y = x << n;
      3'b011: e.y = x >> n;
      3'b100: begin sx = $signed(x) >>> n; e.y = sx; end
      default: begin e.y = x; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Scoreboard and stall monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (sb_on && i_rstn) begin
      if (prev_stall) begin
        check("hold_y", o_Y, held_y);
        check("hold_err", o_err, held_err);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", o_valid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_y", o_Y, e.y);
          check("sb_err", o_err, e.err);
          n_out++;
        end
      end
      if (i_valid && o_ready) exp_q.push_back(ref_model(i_op, i_X, i_shamt));
      prev_stall = o_valid && !i_ready;
      held_y     = o_Y;
      held_err   = o_err;
    end
  end

  // One operand through an idle pipe with the downstream always ready.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [3:0] x,
                         input logic [1:0] s, input logic [3:0] exp_y, input logic exp_err);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_op    = op;
    i_X     = x;
    i_shamt = s;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check({tag, "_v_early"}, o_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_valid"}, o_valid, 1'b1);
    check({tag, "_y"}, o_Y, exp_y);
    check({tag, "_err"}, o_err, exp_err);
    @(posedge clk); #1;
  endtask

  logic [2:0] st_op [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b100, 3'b010};
  logic [3:0] st_x  [8] = '{4'b1001, 4'b1001, 4'b0111, 4'b1000, 4'b1010, 4'b0101, 4'b0110, 4'b1111};
  logic [1:0] st_s  [8] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};

  task automatic run_stream();
    int sent   = 0;
    int cyc    = 0;
    int stalls = 0;
    exp_q.delete();
    n_out      = 0;
    prev_stall = 1'b0;
    sb_on      = 1'b1;
    while ((sent < 8 || n_out < 8) && cyc < 200) begin
      i_ready = !(cyc >= 3 && cyc <= 6);
      i_valid = (sent < 8);
      if (sent < 8) begin
        i_op    = st_op[sent];
        i_X     = st_x[sent];
        i_shamt = st_s[sent];
      end
      @(negedge clk);
      if (cyc == 3) check("full_ready", o_ready, 1'b0);
      if (cyc == 7) check("drain_ready", o_ready, 1'b1);
      if (!o_ready) stalls++;
      if (i_valid && o_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    check("stream_timeout", cyc < 200, 1'b1);
    check("stream_count", n_out, 8);
    check("stream_stalls", stalls, 4);
    check("stream_leftover", exp_q.size(), 0);
    sb_on = 1'b0;
  endtask

  task automatic run_random(input int n_txn);
    int cyc = 0;
    exp_q.delete();
    n_out      = 0;
    prev_stall = 1'b0;
    sb_on      = 1'b1;
    while (n_out < n_txn && cyc < 60000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_op    = 3'($urandom_range(0, 7));
      i_X     = 4'($urandom_range(0, 15));
      i_shamt = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_timeout", n_out >= n_txn, 1'b1);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);
    sb_on = 1'b0;
  endtask

  initial begin
    i_rstn  = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_X     = '0;
    i_shamt = '0;
    i_op    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_y", o_Y, 4'b0000);
    check("rst_err", o_err, 1'b0);
    i_rstn = 1'b1;
    check("rst_ready", o_ready, 1'b1);

    run_one("sra_1010_1", 3'b100, 4'b1010, 2'd1, 4'b1101, 1'b0);
    run_one("rol_1001_1", 3'b000, 4'b1001, 2'd1, 4'b0011, 1'b0);
    run_one("ror_1001_1", 3'b001, 4'b1001, 2'd1, 4'b1100, 1'b0);
    run_one("sll_0111_2", 3'b010, 4'b0111, 2'd2, 4'b1100, 1'b0);
    run_one("srl_1000_3", 3'b011, 4'b1000, 2'd3, 4'b0001, 1'b0);
    run_one("sra_0110_3", 3'b100, 4'b0110, 2'd3, 4'b0000, 1'b0);
    for (int op = 0; op < 5; op++) begin
      run_one($sformatf("zero_shamt_op%0d", op), 3'(op), 4'b1011, 2'd0, 4'b1011, 1'b0);
    end
    run_one("illegal_110", 3'b110, 4'b0101, 2'd2, 4'b0101, 1'b1);

    run_stream();

    // Fill both stages with illegal-op operands, then reset for one edge.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_op    = 3'b111;
    i_X     = 4'b0101;
    i_shamt = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    check("full_before_rst", o_ready, 1'b0);
    check("full_err_before_rst", o_err, 1'b1);
    i_valid = 1'b0;
    i_rstn  = 1'b0;
    @(posedge clk); #1;
    i_rstn  = 1'b1;
    check("flush_valid", o_valid, 1'b0);
    check("flush_y", o_Y, 4'b0000);
    check("flush_err", o_err, 1'b0);
    check("flush_ready", o_ready, 1'b1);
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("flush_no_ghost", o_valid, 1'b0);
    end

    run_random(10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
